// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch redirect sequencer:
// select codes, FSM encoding and control-flow classification.
package branch_pkg;

  localparam logic [5:0] SEL_JAL  = 6'd3;
  localparam logic [5:0] SEL_JALR = 6'd4;
  localparam logic [5:0] SEL_BEQ  = 6'd5;
  localparam logic [5:0] SEL_BNE  = 6'd6;
  localparam logic [5:0] SEL_BLT  = 6'd7;
  localparam logic [5:0] SEL_BGE  = 6'd8;
  localparam logic [5:0] SEL_BLTU = 6'd9;
  localparam logic [5:0] SEL_BGEU = 6'd10;

  localparam int DRAIN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_JUMP = 2'd1,
    KIND_COND = 2'd2
  } kind_e;

  function automatic kind_e classify(input logic [5:0] code);
    kind_e k;
    case (code)
      SEL_JAL, SEL_JALR:                         k = KIND_JUMP;
      SEL_BEQ, SEL_BNE, SEL_BLT, SEL_BGE,
      SEL_BLTU, SEL_BGEU:                        k = KIND_COND;
      default:                                   k = KIND_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect target: pc+imm for JAL/branches,
// (rs1+imm) with bit 0 cleared for JALR. Wraps modulo 2^32.
module branch_target_gen
  import branch_pkg::*;
(
  input  logic [5:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] target
);

  logic        is_jalr;
  logic [31:0] base;
  logic [31:0] sum;

  always_comb begin
    is_jalr = (sel == SEL_JALR);
    base    = is_jalr ? rs1 : pc;
    sum     = base + imm;
    target  = is_jalr ? (sum & ~32'h1) : sum;
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirect sequencer for the not-taken-predicted pipeline: issues a registered
// PC redirect, sequences IF/ID and ID/EX flushes, and counts resolutions.
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [5:0]       ex_aluSelect,
  input  logic             branch_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1,
  input  logic             stall,
  output logic             pc_sel,
  output logic [31:0]      pc_target,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] redirect_count
);

  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [31:0]         pc_target_q, pc_target_d;
  logic                pc_sel_q, pc_sel_d;
  logic                flush_ifid_q, flush_ifid_d;
  logic                flush_idex_q, flush_idex_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    branch_count_q, branch_count_d;
  logic [CNT_W-1:0]    redirect_count_q, redirect_count_d;

  kind_e               kind;
  logic                accept;
  logic                redirect;
  logic [31:0]         target;

  branch_target_gen u_target (
    .sel    (ex_aluSelect),
    .pc     (ex_pc),
    .imm    (ex_imm),
    .rs1    (ex_rs1),
    .target (target)
  );

  always_comb begin
    kind     = classify(ex_aluSelect);
    accept   = ex_valid && !stall && (state_q == ST_IDLE) && (kind != KIND_NONE);
    redirect = accept && ((kind == KIND_JUMP) || branch_taken);
  end

  always_comb begin
    state_d          = state_q;
    drain_d          = drain_q;
    pc_target_d      = pc_target_q;
    branch_count_d   = branch_count_q;
    redirect_count_d = redirect_count_q;

    if (accept && kind == KIND_COND) branch_count_d = branch_count_q + CNT_ONE;
    if (redirect)                    redirect_count_d = redirect_count_q + CNT_ONE;

    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          state_d     = ST_REDIRECT;
          pc_target_d = target;
        end
      end
      ST_REDIRECT: begin
        if (!stall) begin
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        // drain_q counts remaining IF/ID-only flush cycles, including this one
        if (!stall) begin
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = ST_IDLE;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they appear one cycle after the decision
    pc_sel_d     = (state_d == ST_REDIRECT);
    flush_idex_d = (state_d == ST_REDIRECT);
    flush_ifid_d = (state_d == ST_REDIRECT) || (state_d == ST_DRAIN);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      drain_q          <= '0;
      pc_target_q      <= '0;
      pc_sel_q         <= 1'b0;
      flush_ifid_q     <= 1'b0;
      flush_idex_q     <= 1'b0;
      busy_q           <= 1'b0;
      branch_count_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      drain_q          <= drain_d;
      pc_target_q      <= pc_target_d;
      pc_sel_q         <= pc_sel_d;
      flush_ifid_q     <= flush_ifid_d;
      flush_idex_q     <= flush_idex_d;
      busy_q           <= busy_d;
      branch_count_q   <= branch_count_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign pc_sel         = pc_sel_q;
  assign pc_target      = pc_target_q;
  assign flush_ifid     = flush_ifid_q;
  assign flush_idex     = flush_idex_q;
  assign busy           = busy_q;
  assign branch_count   = branch_count_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed EX-stage vectors push
// hand-computed per-cycle expectations; a monitor pops and compares them.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [5:0]  ex_aluSelect;
  logic        branch_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        stall;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        flush_ifid;
  logic        flush_idex;
  logic        busy;
  logic [31:0] branch_count;
  logic [31:0] redirect_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    string       name;
    logic        ps;
    logic        fi;
    logic        fx;
    logic        bz;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] rc;
  } exp_t;

  exp_t sb_q[$];

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_aluSelect   (ex_aluSelect),
    .branch_taken   (branch_taken),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1         (ex_rs1),
    .stall          (stall),
    .pc_sel         (pc_sel),
    .pc_target      (pc_target),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .busy           (busy),
    .branch_count   (branch_count),
    .redirect_count (redirect_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: 4 time units after each edge, compare every expectation due this cycle
  initial begin
    forever begin
      @(posedge clk);
      #4;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, ":pc_sel"},         32'(pc_sel),     32'(e.ps));
        check({e.name, ":flush_ifid"},     32'(flush_ifid), 32'(e.fi));
        check({e.name, ":flush_idex"},     32'(flush_idex), 32'(e.fx));
        check({e.name, ":busy"},           32'(busy),       32'(e.bz));
        check({e.name, ":pc_target"},      pc_target,       e.tgt);
        check({e.name, ":branch_count"},   branch_count,    e.bc);
        check({e.name, ":redirect_count"}, redirect_count,  e.rc);
      end
    end
  end

  task automatic step(input string name, input logic v, input logic [5:0] code,
                      input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [31:0] rs1, input logic st,
                      input logic ps, input logic fi, input logic fx,
                      input logic [31:0] tgt, input logic [31:0] bc, input logic [31:0] rc);
    exp_t e;
    ex_valid     = v;
    ex_aluSelect = code;
    branch_taken = tk;
    ex_pc        = pc;
    ex_imm       = imm;
    ex_rs1       = rs1;
    stall        = st;
    e.due  = cyc + 1;
    e.name = name;
    e.ps   = ps;
    e.fi   = fi;
    e.fx   = fx;
    e.bz   = fi;
    e.tgt  = tgt;
    e.bc   = bc;
    e.rc   = rc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    ex_valid     = 1'b0;
    ex_aluSelect = 6'd0;
    branch_taken = 1'b0;
    ex_pc        = 32'h0;
    ex_imm       = 32'h0;
    ex_rs1       = 32'h0;
    stall        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:pc_sel",         32'(pc_sel),     32'h0);
    check("reset:flush_ifid",     32'(flush_ifid), 32'h0);
    check("reset:flush_idex",     32'(flush_idex), 32'h0);
    check("reset:busy",           32'(busy),       32'h0);
    check("reset:pc_target",      pc_target,       32'h0);
    check("reset:branch_count",   branch_count,    32'h0);
    check("reset:redirect_count", redirect_count,  32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    //   name             v  code   tk pc            imm           rs1        st  ps fi fx tgt           bc rc
    step("beq_taken",     1, 6'd5,  1, 32'h100,      32'h20,       32'h0,     0,  1, 1, 1, 32'h120,     1, 1);
    step("beq_drain",     0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 1, 0, 32'h120,     1, 1);
    step("beq_idle",      0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 0, 0, 32'h120,     1, 1);
    step("bne_not_taken", 1, 6'd6,  0, 32'h300,      32'h40,       32'h0,     0,  0, 0, 0, 32'h120,     2, 1);
    step("jalr",          1, 6'd4,  0, 32'h500,      32'h4,        32'h1003,  0,  1, 1, 1, 32'h1006,    2, 2);
    step("stall_redir_1", 1, 6'd5,  1, 32'h600,      32'h8,        32'h0,     1,  1, 1, 1, 32'h1006,    2, 2);
    step("stall_redir_2", 1, 6'd5,  1, 32'h600,      32'h8,        32'h0,     1,  1, 1, 1, 32'h1006,    2, 2);
    step("stall_redir_3", 1, 6'd5,  1, 32'h600,      32'h8,        32'h0,     1,  1, 1, 1, 32'h1006,    2, 2);
    step("stall_release", 1, 6'd5,  1, 32'h600,      32'h8,        32'h0,     0,  0, 1, 0, 32'h1006,    2, 2);
    step("jalr_idle",     0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 0, 0, 32'h1006,    2, 2);
    step("idle_stall",    1, 6'd5,  1, 32'h200,      32'hFFFFFFF0, 32'h0,     1,  0, 0, 0, 32'h1006,    2, 2);
    step("stall_drop",    1, 6'd5,  1, 32'h200,      32'hFFFFFFF0, 32'h0,     0,  1, 1, 1, 32'h1F0,     3, 3);
    step("to_drain",      0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 1, 0, 32'h1F0,     3, 3);

    // Mid-DRAIN asynchronous reset, applied away from any clock edge
    #5;
    reset = 1'b1;
    #1;
    check("reset_async:pc_sel",         32'(pc_sel),     32'h0);
    check("reset_async:flush_ifid",     32'(flush_ifid), 32'h0);
    check("reset_async:flush_idex",     32'(flush_idex), 32'h0);
    check("reset_async:busy",           32'(busy),       32'h0);
    check("reset_async:pc_target",      pc_target,       32'h0);
    check("reset_async:branch_count",   branch_count,    32'h0);
    check("reset_async:redirect_count", redirect_count,  32'h0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    step("after_reset",   0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 0, 0, 32'h0,       0, 0);
    step("illegal_code",  1, 6'd63, 1, 32'h40,       32'h40,       32'h40,    0,  0, 0, 0, 32'h0,       0, 0);
    step("alu_code",      1, 6'd2,  1, 32'h40,       32'h40,       32'h40,    0,  0, 0, 0, 32'h0,       0, 0);
    step("jal_wrap",      1, 6'd3,  0, 32'hFFFFFFF0, 32'h20,       32'h0,     0,  1, 1, 1, 32'h10,      0, 1);
    step("jal_drain",     0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 1, 0, 32'h10,      0, 1);
    step("jal_idle",      0, 6'd0,  0, 32'h0,        32'h0,        32'h0,     0,  0, 0, 0, 32'h10,      0, 1);

    repeat (3) @(posedge clk);
    #6;
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
